// File: rtl/tb_pkg.sv
// Shared definitions for the Viterbi traceback engine: FSM encoding,
// default parameter values and a constant-foldable clog2.
package tb_pkg;

   localparam int DEF_K         = 7;
   localparam int DEF_TB_DEPTH  = 64;
   localparam int DEF_DEC_LEN   = 32;
   localparam int DEF_MEM_DEPTH = 128;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      UPD,
      DRAIN,
      FIN
   } tbState_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/tb_lifo.sv
// Small push/pop stack used to reverse traceback-order bits into
// chronological order (only instantiated when TB_LIFO_EN is defined).
module tb_lifo
   import tb_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
)(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int IW = (DEPTH > 1) ? clog2(DEPTH) : 1;
   localparam int CW = IW + 1;

   logic [WIDTH-1:0] store [1<<IW];
   logic [CW-1:0]    count;
   logic [IW-1:0]    wrIdx;
   logic [IW-1:0]    topIdx;

   assign wrIdx   = count[IW-1:0];
   assign topIdx  = wrIdx - 1'b1;
   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign popData = empty ? '0 : store[topIdx];

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + 1'b1;
      end else if (pop && !empty) begin
         count <= count - 1'b1;
      end
   end

   // Storage carries data only; occupancy is tracked by count.
   always_ff @(posedge Clock) begin
      if (push && !full) store[wrIdx] <= pushData;
   end

endmodule

// File: rtl/traceback_engine.sv
// Viterbi survivor-memory traceback: walks TB_DEPTH stages backwards from
// end_addr and emits the last DEC_LEN decisions. Optional macro: TB_LIFO_EN.
module traceback_engine
   import tb_pkg::*;
#(
   parameter int K         = DEF_K,
   parameter int TB_DEPTH  = DEF_TB_DEPTH,
   parameter int DEC_LEN   = DEF_DEC_LEN,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH
)(
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic                          start,
   input  logic [K-2:0]                  start_state,
   input  logic [clog2(MEM_DEPTH)-1:0]   end_addr,
   output logic                          mem_rd_en,
   output logic [clog2(MEM_DEPTH)-1:0]   mem_addr,
   input  logic [(1<<(K-1))-1:0]         mem_data,
   output logic                          out_valid,
   output logic                          out_bit,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done
);

   localparam int SW = K - 1;
   localparam int AW = clog2(MEM_DEPTH);
   localparam logic [AW-1:0] FIRST_OUT  = AW'(TB_DEPTH - DEC_LEN);
   localparam logic [AW-1:0] LAST_STAGE = AW'(TB_DEPTH - 1);

   tbState_t      state;
   tbState_t      nextState;
   logic [SW-1:0] curState;
   logic [AW-1:0] basePtr;
   logic [AW-1:0] stageIdx;
   logic          rdDly;
   logic          survHold;
   logic          survBit;
   logic          outStage;
   logic          lastStage;
   logic          advance;

`ifdef TB_LIFO_EN
   localparam logic [AW-1:0] LAST_POP = AW'(DEC_LEN - 1);
   logic push;
   logic pop;
   logic popData;
   logic lifoFull;
   logic lifoEmpty;

   tb_lifo #(
      .WIDTH (1),
      .DEPTH (DEC_LEN)
   ) uLifo (
      .Clock    (Clock),
      .Reset    (Reset),
      .push     (push),
      .pushData (curState[SW-1]),
      .pop      (pop),
      .popData  (popData),
      .full     (lifoFull),
      .empty    (lifoEmpty)
   );
`endif

   assign outStage  = (stageIdx >= FIRST_OUT);
   assign lastStage = (stageIdx == LAST_STAGE);
   // Memory data is only valid the cycle after the read; a stalled UPD reuses the held copy.
   assign survBit   = rdDly ? mem_data[curState] : survHold;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         curState <= '0;
         basePtr  <= '0;
         stageIdx <= '0;
         rdDly    <= 1'b0;
      end else begin
         state <= nextState;
         rdDly <= (state == RD);
         case (state)
            IDLE: begin
               if (start) begin
                  curState <= start_state;
                  basePtr  <= end_addr;
                  stageIdx <= '0;
               end
            end
            UPD: begin
               if (advance) begin
                  curState <= {curState[SW-2:0], survBit};
`ifdef TB_LIFO_EN
                  stageIdx <= lastStage ? '0 : stageIdx + 1'b1;
`else
                  stageIdx <= stageIdx + 1'b1;
`endif
               end
            end
`ifdef TB_LIFO_EN
            DRAIN: begin
               if (pop) stageIdx <= stageIdx + 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (state == UPD) survHold <= survBit;
   end

   always_comb begin
      nextState = state;
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      out_valid = 1'b0;
      out_bit   = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      advance   = 1'b0;
`ifdef TB_LIFO_EN
      push      = 1'b0;
      pop       = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) nextState = RD;
         end
         RD: begin
            mem_rd_en = 1'b1;
            mem_addr  = basePtr - stageIdx;
            nextState = UPD;
         end
         UPD: begin
`ifdef TB_LIFO_EN
            advance = 1'b1;
            push    = outStage && !lifoFull;
`else
            out_valid = outStage;
            out_bit   = outStage && curState[SW-1];
            advance   = !outStage || out_ready;
`endif
            if (advance) begin
`ifdef TB_LIFO_EN
               nextState = lastStage ? DRAIN : RD;
`else
               nextState = lastStage ? FIN : RD;
`endif
            end
         end
`ifdef TB_LIFO_EN
         DRAIN: begin
            out_valid = !lifoEmpty;
            out_bit   = !lifoEmpty && popData;
            pop       = !lifoEmpty && out_ready;
            if (pop && (stageIdx == LAST_POP)) nextState = FIN;
         end
`endif
         FIN: begin
            done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_traceback_engine.sv
// Randomized scoreboard bench for traceback_engine (K=3, TB_DEPTH=8,
// DEC_LEN=4, MEM_DEPTH=16); follows TB_LIFO_EN when defined.
module tb_traceback_engine;

   localparam int K         = 3;
   localparam int TB_DEPTH  = 8;
   localparam int DEC_LEN   = 4;
   localparam int MEM_DEPTH = 16;
   localparam int SW        = K - 1;
   localparam int AW        = 4;
   localparam int NS        = 1 << SW;
`ifdef TB_LIFO_EN
   localparam int EXTRA     = DEC_LEN;
`else
   localparam int EXTRA     = 0;
`endif

   logic          Clock = 1'b0;
   logic          Reset = 1'b0;
   logic          start = 1'b0;
   logic [SW-1:0] start_state = '0;
   logic [AW-1:0] end_addr = '0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [NS-1:0] mem_data;
   logic          out_valid;
   logic          out_bit;
   logic          out_ready = 1'b1;
   logic          busy;
   logic          done;

   traceback_engine #(
      .K         (K),
      .TB_DEPTH  (TB_DEPTH),
      .DEC_LEN   (DEC_LEN),
      .MEM_DEPTH (MEM_DEPTH)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .start       (start),
      .start_state (start_state),
      .end_addr    (end_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .out_valid   (out_valid),
      .out_bit     (out_bit),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   always #5 Clock = ~Clock;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic [NS-1:0] surv [MEM_DEPTH];
   int            expAddr[$];
   int            expBit[$];
   int            startCyc = 0;
   int            expStall = 0;
   int            passId = 0;
   int            abortedId = 0;
   int            doneId = 0;
   int            doneCnt = 0;
   int            stallCnt = 0;
   int            readyMode = 0;
   int            stallUsed = 0;
   bit            prevStall = 1'b0;
   bit            prevBit = 1'b0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge Clock) cyc <= cyc + 1;

   // Survivor memory: answers one cycle after a read, garbage otherwise.
   always @(posedge Clock) mem_data <= mem_rd_en ? surv[mem_addr] : NS'($urandom);

   always @(posedge Clock) begin
      #1;
      case (readyMode)
         1: begin out_ready = ($urandom % 3) != 0; stallUsed = 0; end
         2: begin
            if (out_valid && stallUsed < 5) begin
               out_ready = 1'b0;
               stallUsed++;
            end else begin
               out_ready = 1'b1;
            end
         end
         default: begin out_ready = 1'b1; stallUsed = 0; end
      endcase
   end

   // Monitor: pops expectations whenever the DUT presents something.
   always @(negedge Clock) begin
      if (!Reset) begin
         prevStall = 1'b0;
         stallCnt  = 0;
      end else begin
         if (prevStall) begin
            check("hold_valid", out_valid, 1);
            check("hold_bit", out_bit, prevBit);
         end
         if (mem_rd_en) begin
            if (expAddr.size() == 0) check("addr_unexpected", 1, 0);
            else check("mem_addr", mem_addr, expAddr.pop_front());
         end
         if (out_valid && !out_ready) begin
            stallCnt++;
            check("stall_no_read", mem_rd_en, 0);
         end
         if (out_valid && out_ready) begin
            if (expBit.size() == 0) check("bit_unexpected", 1, 0);
            else check("out_bit", out_bit, expBit.pop_front());
         end
         prevStall = out_valid && !out_ready;
         prevBit   = out_bit;
         if (done) begin
            doneCnt++;
            check("done_expected", (passId != doneId && passId != abortedId) ? 1 : 0, 1);
            check("busy_at_done", busy, 1);
            check("latency", cyc - startCyc,
                  2 * TB_DEPTH + 1 + EXTRA + ((expStall >= 0) ? expStall : stallCnt));
            doneId   = passId;
            stallCnt = 0;
         end
      end
   end

   // Reference model: plain trellis walk over the survivor table.
   task automatic build_expect(input int s0, input int e);
      int st;
      int a;
      int bits[$];
      st = s0;
      for (int i = 0; i < TB_DEPTH; i++) begin
         a = (e - i + MEM_DEPTH) % MEM_DEPTH;
         expAddr.push_back(a);
         if (i >= TB_DEPTH - DEC_LEN) bits.push_back((st >> (SW - 1)) & 1);
         st = ((st << 1) | int'(surv[a][st])) % NS;
      end
`ifdef TB_LIFO_EN
      for (int j = bits.size() - 1; j >= 0; j--) expBit.push_back(bits[j]);
`else
      foreach (bits[j]) expBit.push_back(bits[j]);
`endif
   endtask

   task automatic fill_surv(input int mode);
      for (int a = 0; a < MEM_DEPTH; a++)
         surv[a] = (mode == 0) ? '0 : (mode == 1) ? '1 : NS'($urandom);
   endtask

   task automatic launch(input int s0, input int e, input int mode, input int stall);
      @(posedge Clock);
      #1;
      build_expect(s0, e);
      readyMode   = mode;
      expStall    = stall;
      passId++;
      start_state = SW'(s0);
      end_addr    = AW'(e);
      start       = 1'b1;
      startCyc    = cyc;
      @(posedge Clock);
      #1;
      start       = 1'b0;
      start_state = SW'($urandom);
      end_addr    = AW'($urandom);
   endtask

   task automatic run_pass(input int s0, input int e, input int mode, input int stall,
                           input bit poke);
      int d0;
      d0 = doneCnt;
      launch(s0, e, mode, stall);
      if (poke) begin
         repeat (3) @(posedge Clock);
         #1 start = 1'b1;
         @(posedge Clock);
         #1 start = 1'b0;
      end
      for (int n = 0; n < 300 && doneCnt == d0; n++) @(posedge Clock);
      check("done_seen", doneCnt - d0, 1);
      #1;
      check("addr_queue_empty", expAddr.size(), 0);
      check("bit_queue_empty", expBit.size(), 0);
      check("idle_after_done", busy, 0);
      readyMode = 0;
   endtask

   initial begin
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", out_valid, 0);
      check("rst_bit", out_bit, 0);
      check("rst_rd_en", mem_rd_en, 0);
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b1;

      fill_surv(0);
      run_pass(0, 7, 0, 0, 1'b0);
      fill_surv(2);
      run_pass(1, 2, 0, 0, 1'b0);
      fill_surv(1);
      run_pass(0, 3, 0, 0, 1'b0);
      fill_surv(2);
      run_pass(2, 9, 2, 5, 1'b0);
      fill_surv(2);
      run_pass(3, 5, 0, 0, 1'b1);

      // Abort mid-pass, then confirm a fresh pass runs cleanly.
      fill_surv(2);
      launch(1, 12, 0, 0);
      repeat (4) @(posedge Clock);
      #1 Reset = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_valid", out_valid, 0);
      check("abort_bit", out_bit, 0);
      check("abort_rd_en", mem_rd_en, 0);
      check("abort_addr", mem_addr, 0);
      expAddr.delete();
      expBit.delete();
      abortedId = passId;
      @(posedge Clock);
      #1 Reset = 1'b1;
      repeat (20) @(posedge Clock);
      #1 check("abort_idle", busy, 0);
      fill_surv(2);
      run_pass(2, 0, 0, 0, 1'b0);

      for (int p = 0; p < 20; p++) begin
         fill_surv(2);
         run_pass(int'($urandom % NS), int'($urandom % MEM_DEPTH), 1, -1, p[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
